// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and the transmitter
// on the same link.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_BAUD       = 9600;
  localparam int UART_DIV_CLK_HZ = UART_BAUD * UART_OVERSAMPLE;
  // Div_CLK ticks per bit period; the divider output runs at OVERSAMPLE x baud.
  localparam int UART_BAUD_DIV   = UART_OVERSAMPLE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value so an idle-high line does not look active after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: start-bit qualification at mid-bit, mid-bit
// data sampling, stop-bit check, and a valid/ack host handshake with overrun.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 Div_CLK,
  input  logic                 RST,
  input  logic                 RX,
  input  logic                 DATA_ACK,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxs;

  uart_state_e          state_d, state_q;
  logic [TW-1:0]        tick_d, tick_q;
  logic [BW-1:0]        bit_d, bit_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 frame_err_d, frame_err_q;
  logic                 overrun_d, overrun_q;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk(Div_CLK),
    .rst(RST),
    .d  (RX),
    .q  (rxs)
  );

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    if (valid_q && DATA_ACK) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end

      ST_START: begin
        if (tick_q == TICK_MID) begin
          // A line that is high again at mid start bit was only a glitch.
          if (!rxs) begin
            state_d = ST_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rxs) begin
            // New byte always wins; overrun only if the old one was not acked now.
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !DATA_ACK) begin
              overrun_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Div_CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign OVERRUN    = overrun_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: good frames, false start, framing
// error with break, overrun, ack coincident with stop sample, reset mid-frame.
module tb_uart_rx_oversample;
  import uart_pkg::*;

  localparam int OS    = UART_OVERSAMPLE;
  localparam int NB    = UART_DATA_BITS;
  localparam int FRAME = OS * (NB + 2);
  // Loop index whose edge carries the stop sample: 2 sync edges + 1 IDLE edge,
  // OS/2 to mid start, then OS per data bit and stop bit.
  localparam int STOP_C = 3 + OS / 2 + OS * (NB + 1);

  logic          Div_CLK = 1'b0;
  logic          RST;
  logic          RX;
  logic          DATA_ACK;
  logic [NB-1:0] DATA;
  logic          DATA_VALID;
  logic          FRAME_ERR;
  logic          OVERRUN;
  logic          BUSY;

  int n_checks = 0;
  int n_errors = 0;
  int fe_total = 0;

  logic          valid_before;
  logic          valid_after;
  logic          ovr_after;
  logic [NB-1:0] data_after;

  uart_rx_oversample #(
    .OVERSAMPLE(OS),
    .DATA_BITS (NB)
  ) dut (
    .Div_CLK   (Div_CLK),
    .RST       (RST),
    .RX        (RX),
    .DATA_ACK  (DATA_ACK),
    .DATA      (DATA),
    .DATA_VALID(DATA_VALID),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .BUSY      (BUSY)
  );

  always #5 Div_CLK = ~Div_CLK;

  always @(negedge Div_CLK) begin
    if (FRAME_ERR === 1'b1) fe_total++;
  end

  // Drives one full frame; ack_c selects the loop index whose following edge samples DATA_ACK=1.
  task automatic send_frame(input logic [NB-1:0] b, input logic stop_bit, input int ack_c);
    logic [NB+1:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int c = 0; c < FRAME; c++) begin
      @(posedge Div_CLK);
      #1;
      if (c == STOP_C - 1) valid_before = DATA_VALID;
      if (c == STOP_C) begin
        valid_after = DATA_VALID;
        data_after  = DATA;
        ovr_after   = OVERRUN;
      end
      RX       = bits[c/OS];
      DATA_ACK = (c == ack_c);
    end
  endtask

  task automatic pulse_ack();
    @(posedge Div_CLK);
    #1 DATA_ACK = 1'b1;
    @(posedge Div_CLK);
    #1 DATA_ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; RX = 1'b1; DATA_ACK = 1'b0;
    repeat (3) @(posedge Div_CLK);
    #1;
    n_checks++; if (DATA !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", DATA); end
    n_checks++; if (DATA_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (FRAME_ERR !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b expected 0", FRAME_ERR); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", OVERRUN); end
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RST = 1'b0;
    repeat (4) @(posedge Div_CLK);
    #1;
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b expected 0", BUSY); end
  endtask

  task automatic test_good_frame();
    int fe0;
    fe0 = fe_total;
    send_frame(8'hA5, 1'b1, -1);
    n_checks++; if (valid_before !== 1'b0) begin n_errors++; $display("FAIL good_valid_early: got %b expected 0", valid_before); end
    n_checks++; if (valid_after !== 1'b1) begin n_errors++; $display("FAIL good_valid_at_stop: got %b expected 1", valid_after); end
    n_checks++; if (data_after !== 8'hA5) begin n_errors++; $display("FAIL good_data: got %h expected a5", data_after); end
    n_checks++; if (ovr_after !== 1'b0) begin n_errors++; $display("FAIL good_overrun: got %b expected 0", ovr_after); end
    n_checks++; if (fe_total - fe0 !== 0) begin n_errors++; $display("FAIL good_frame_err: got %0d pulses expected 0", fe_total - fe0); end
    repeat (3) @(posedge Div_CLK);
    pulse_ack();
    n_checks++; if (DATA_VALID !== 1'b0) begin n_errors++; $display("FAIL ack_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (DATA !== 8'hA5) begin n_errors++; $display("FAIL ack_data_hold: got %h expected a5", DATA); end
    pulse_ack();
    n_checks++; if (DATA_VALID !== 1'b0 || OVERRUN !== 1'b0) begin n_errors++; $display("FAIL stray_ack: got valid=%b ovr=%b expected 0 0", DATA_VALID, OVERRUN); end
  endtask

  task automatic test_false_start();
    logic busy_seen;
    int   fe0;
    busy_seen = 1'b0;
    fe0 = fe_total;
    for (int c = 0; c < 24; c++) begin
      @(posedge Div_CLK);
      #1;
      if (BUSY === 1'b1) busy_seen = 1'b1;
      RX = (c < 4) ? 1'b0 : 1'b1;
    end
    n_checks++; if (busy_seen !== 1'b1) begin n_errors++; $display("FAIL false_busy_seen: got %b expected 1", busy_seen); end
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL false_back_idle: got %b expected 0", BUSY); end
    n_checks++; if (DATA_VALID !== 1'b0) begin n_errors++; $display("FAIL false_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (fe_total - fe0 !== 0 || OVERRUN !== 1'b0) begin n_errors++; $display("FAIL false_flags: got fe=%0d ovr=%b expected 0 0", fe_total - fe0, OVERRUN); end
    send_frame(8'h3C, 1'b1, -1);
    n_checks++; if (data_after !== 8'h3C || valid_after !== 1'b1) begin n_errors++; $display("FAIL false_next_frame: got %h/%b expected 3c/1", data_after, valid_after); end
    pulse_ack();
  endtask

  task automatic test_framing_error();
    int fe0;
    fe0 = fe_total;
    send_frame(8'h55, 1'b0, -1);
    n_checks++; if (valid_after !== 1'b0) begin n_errors++; $display("FAIL fe_valid: got %b expected 0", valid_after); end
    n_checks++; if (data_after !== 8'h3C) begin n_errors++; $display("FAIL fe_data_kept: got %h expected 3c", data_after); end
    for (int c = 0; c < 40; c++) begin
      @(posedge Div_CLK);
      #1 RX = 1'b0;
    end
    n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL fe_break_busy: got %b expected 1", BUSY); end
    n_checks++; if (DATA_VALID !== 1'b0) begin n_errors++; $display("FAIL fe_break_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (fe_total - fe0 !== 1) begin n_errors++; $display("FAIL fe_pulse_len: got %0d cycles expected 1", fe_total - fe0); end
    RX = 1'b1;
    repeat (5) @(posedge Div_CLK);
    #1;
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL fe_break_exit: got %b expected 0", BUSY); end
    send_frame(8'h0F, 1'b1, -1);
    n_checks++; if (data_after !== 8'h0F || valid_after !== 1'b1) begin n_errors++; $display("FAIL fe_next_frame: got %h/%b expected 0f/1", data_after, valid_after); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1);
    n_checks++; if (data_after !== 8'h11 || ovr_after !== 1'b0) begin n_errors++; $display("FAIL ovr_first: got %h ovr=%b expected 11 ovr=0", data_after, ovr_after); end
    send_frame(8'h22, 1'b1, -1);
    n_checks++; if (data_after !== 8'h22) begin n_errors++; $display("FAIL ovr_data: got %h expected 22", data_after); end
    n_checks++; if (valid_after !== 1'b1) begin n_errors++; $display("FAIL ovr_valid: got %b expected 1", valid_after); end
    n_checks++; if (ovr_after !== 1'b1) begin n_errors++; $display("FAIL ovr_flag: got %b expected 1", ovr_after); end
    pulse_ack();
    n_checks++; if (DATA_VALID !== 1'b0 || OVERRUN !== 1'b0) begin n_errors++; $display("FAIL ovr_ack_clear: got valid=%b ovr=%b expected 0 0", DATA_VALID, OVERRUN); end
  endtask

  task automatic test_ack_at_stop();
    send_frame(8'h66, 1'b1, -1);
    send_frame(8'h77, 1'b1, STOP_C - 1);
    n_checks++; if (valid_before !== 1'b1) begin n_errors++; $display("FAIL coin_pending: got %b expected 1", valid_before); end
    n_checks++; if (data_after !== 8'h77) begin n_errors++; $display("FAIL coin_data: got %h expected 77", data_after); end
    n_checks++; if (valid_after !== 1'b1) begin n_errors++; $display("FAIL coin_valid: got %b expected 1", valid_after); end
    n_checks++; if (ovr_after !== 1'b0) begin n_errors++; $display("FAIL coin_overrun: got %b expected 0", ovr_after); end
    pulse_ack();
  endtask

  task automatic test_reset_mid_frame();
    logic [NB+1:0] bits;
    bits = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < OS * 5; c++) begin
      @(posedge Div_CLK);
      #1 RX = bits[c/OS];
    end
    n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL mid_busy: got %b expected 1", BUSY); end
    #2 RST = 1'b1;
    #1;
    n_checks++; if (DATA !== 8'h00) begin n_errors++; $display("FAIL mid_rst_data: got %h expected 00", DATA); end
    n_checks++; if (BUSY !== 1'b0 || DATA_VALID !== 1'b0) begin n_errors++; $display("FAIL mid_rst_state: got busy=%b valid=%b expected 0 0", BUSY, DATA_VALID); end
    n_checks++; if (OVERRUN !== 1'b0 || FRAME_ERR !== 1'b0) begin n_errors++; $display("FAIL mid_rst_flags: got ovr=%b fe=%b expected 0 0", OVERRUN, FRAME_ERR); end
    RX = 1'b1;
    repeat (3) @(posedge Div_CLK);
    #1 RST = 1'b0;
    repeat (4) @(posedge Div_CLK);
    #1;
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL mid_after_release: got %b expected 0", BUSY); end
    send_frame(8'h81, 1'b1, -1);
    n_checks++; if (data_after !== 8'h81 || valid_after !== 1'b1) begin n_errors++; $display("FAIL mid_next_frame: got %h/%b expected 81/1", data_after, valid_after); end
    n_checks++; if (ovr_after !== 1'b0) begin n_errors++; $display("FAIL mid_next_overrun: got %b expected 0", ovr_after); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_ack_at_stop();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
